// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: coprocessor pixel-write handshake into the framebuffer
// arbiter. The coprocessor is the master, the arbiter is the slave.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous framebuffer RAM between
// VGA scanout reads, coprocessor pixel writes and a clear-screen sweep.
// Scanout reads always win; pending writes take the next free slot; the
// clear sweep only uses slots nobody else wants.
// Optional build macro: FB_ARB_WFIFO_EN -- the write store becomes a FIFO of
// FIFO_DEPTH entries instead of a single hold register.
//
// state | meaning
// IDLE  | normal operation, clr_req accepted
// DRAIN | clear requested, wr_ready low, emptying the write store
// CLEAR | sweeping every address with the latched fill color in free slots
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              vga_ce,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    output logic [7:0]        vga_color,
    vga_fb_arbiter_if.slave   wr_if,
    input  logic              clr_req,
    input  logic [7:0]        clr_color,
    output logic              clr_busy,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]        clr_color_q, clr_color_d;
    logic              cap_q, cap_d, cap_vis_q, cap_vis_d;
    logic [7:0]        vga_color_q, vga_color_d;
    logic              wr_err_q, wr_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] y_half, x_half, rd_addr;
    logic              visible, rd_slot, wr_slot, clr_slot;
    logic              wr_accept, in_range, push, pop;
    logic              store_empty, store_full;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;

    // Framebuffer is half resolution; y'*320 is built as y'*256 + y'*64.
    assign y_half  = ADDR_W'(vga_y[9:1]);
    assign x_half  = ADDR_W'(vga_x[9:1]);
    assign rd_addr = (y_half << 8) + (y_half << 6) + x_half;
    assign visible = (vga_x < 10'd640) && (vga_y < 10'd480);
    assign rd_slot = vga_ce && visible;

    assign clr_busy       = (state_q != S_IDLE);
    assign wr_if.wr_ready = !store_full && !clr_busy;
    assign wr_accept      = wr_if.wr_valid && wr_if.wr_ready;
    assign in_range       = (wr_if.wr_addr < FB_SIZE);
    assign push           = wr_accept && in_range;

    assign wr_slot  = !rd_slot && !store_empty;
    assign clr_slot = !rd_slot && store_empty && (state_q == S_CLEAR);
    assign pop      = wr_slot;

`ifdef FB_ARB_WFIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]        fifo_data_q [FIFO_DEPTH];
    logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;

    assign store_empty = (wptr_q == rptr_q);
    assign store_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                         (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign head_addr   = fifo_addr_q[rptr_q[PTR_W-1:0]];
    assign head_data   = fifo_data_q[rptr_q[PTR_W-1:0]];

    // Pointer advance on accepted in-range writes and on write slots.
    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_addr_q[wptr_q[PTR_W-1:0]] <= wr_if.wr_addr;
            fifo_data_q[wptr_q[PTR_W-1:0]] <= wr_if.wr_data;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge CLOCK_50 or posedge reset_n) begin
        if (reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
`else
    logic              hold_full_q, hold_full_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]        hold_data_q, hold_data_d;

    assign store_empty = !hold_full_q;
    assign store_full  = hold_full_q;
    assign head_addr   = hold_addr_q;
    assign head_data   = hold_data_q;

    // Single hold register: push only when empty, pop only when full.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (pop) begin
            hold_full_d = 1'b0;
        end
        if (push) begin
            hold_full_d = 1'b1;
            hold_addr_d = wr_if.wr_addr;
            hold_data_d = wr_if.wr_data;
        end
    end

    // Hold register state.
    always_ff @(posedge CLOCK_50 or posedge reset_n) begin
        if (reset_n) begin
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end
`endif

    // Clear sequencer next state; clr_req outside IDLE is ignored.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d     = S_DRAIN;
                    clr_color_d = clr_color;
                    clr_cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (store_empty) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_slot) begin
                    if (clr_cnt_q == FB_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port mux by slot priority; an idle cycle holds the last address/data.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_slot) begin
            mem_addr_d = rd_addr;
        end else if (wr_slot) begin
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
        end else if (clr_slot) begin
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = clr_color_q;
        end
    end

    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;
    assign mem_we    = wr_slot || clr_slot;

    // Scanout capture one cycle after the read; off-screen pixels go black.
    always_comb begin
        cap_d       = vga_ce;
        cap_vis_d   = visible;
        vga_color_d = vga_color_q;
        if (cap_q) begin
            vga_color_d = cap_vis_q ? mem_rdata : 8'h00;
        end
        wr_err_d = wr_err_q || (wr_accept && !in_range);
    end

    assign vga_color = vga_color_q;
    assign wr_err    = wr_err_q;

    // Control and datapath registers; reset aborts any clear in progress.
    always_ff @(posedge CLOCK_50 or posedge reset_n) begin
        if (reset_n) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            cap_q       <= 1'b0;
            cap_vis_q   <= 1'b0;
            vga_color_q <= '0;
            wr_err_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            cap_q       <= cap_d;
            cap_vis_q   <= cap_vis_d;
            vga_color_q <= vga_color_d;
            wr_err_q    <= wr_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates a single-port synchronous framebuffer RAM between VGA scanout reads and coprocessor pixel writes, on the CLOCK_50 domain. Sits between the VGA timing module and the color path. It derives a 320x240 framebuffer address from the 640x480 next-pixel coordinates and returns the pixel color. A clear-screen sequencer fills the whole buffer with one color.

## Interface
- ADDR_W, 17, framebuffer address width
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- FIFO_DEPTH, 4, write FIFO depth (power of 2; used only with FB_ARB_WFIFO_EN)

- CLOCK_50  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-high
- vga_ce  in  1  pixel-clock enable, high for one CLOCK_50 cycle per VGA pixel
- vga_x, vga_y  in  10 each  next pixel coordinates from the VGA timing module
- vga_color  out  8  registered pixel color to the VGA color input
- wr_valid  in  1  write request
- wr_ready  out  1  write accept; a transfer occurs when wr_valid and wr_ready are both high
- wr_addr  in  ADDR_W  framebuffer write address
- wr_data  in  8  write color
- clr_req  in  1  single-cycle clear-screen request
- clr_color  in  8  fill color, sampled on clr_req acceptance
- clr_busy  out  1  clear sequence in progress (DRAIN or CLEAR state)
- wr_err  out  1  sticky flag, set when a write with wr_addr >= FB_W*FB_H is accepted
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid one cycle after the address is presented

## Operation
- Read address: (vga_y>>1)*FB_W + (vga_x>>1), computed as 17-bit shift-add ((y'<<8)+(y'<<6) for FB_W=320).
- Visible means vga_x < 640 and vga_y < 480.
- Slot priority for each cycle:
  1. Read: vga_ce=1 and the coordinate is visible.
  2. Write: the pending write store (hold register or FIFO) is non-empty.
  3. Clear write, in CLEAR state only.
  4. Idle: mem_we=0 and mem_addr holds its value.
- A read always wins and is never stalled.
- Non-visible vga_ce: no RAM access; vga_color loads 0x00 on the cycle a read would have captured.
- Write store without the FIFO is a single hold register; wr_ready = !hold_full.
- Accepted writes with an out-of-range address set wr_err and are dropped; they never reach the RAM.
- States:
  - IDLE: accepts clr_req.
  - DRAIN: wr_ready=0; waits until the write store is empty.
  - CLEAR: a 17-bit counter walks 0..FB_W*FB_H-1, writing clr_color in free slots; wr_ready=0. Returns to IDLE after the last address is written.
- clr_req in DRAIN or CLEAR is ignored.
- wr_ready is 0 whenever clr_busy=1.
- clr_req and a write handshake in the same IDLE cycle: the write is accepted, then drains in DRAIN before the sweep starts.
- Reset values: vga_color=0, wr_ready=1, clr_busy=0, wr_err=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, write store empty.
- Reset mid-clear aborts immediately; framebuffer contents are left partially cleared.

## Timing
- Read path:
  - Cycle n: vga_ce=1; mem_addr is driven combinationally from the coordinates.
  - Cycle n+1: mem_rdata is valid and is registered into vga_color at the end of n+1.
  - vga_color is stable from cycle n+2 until the next read capture.
- Write latency: a handshake at cycle n reaches the RAM (mem_we=1) at cycle n+1 at the earliest. It is delayed only by read slots.
- Write service: with vga_ce at 50% duty, at least one write slot occurs every 2 cycles.
- Clear duration: at least 76800 cycles.
- clr_busy rises on the cycle after clr_req and falls on the cycle after the final clear write.

## Configuration
- FB_ARB_WFIFO_EN defined: the write store is a FIFO of FIFO_DEPTH entries; wr_ready = !full, so back-to-back writes are accepted until full.
- FB_ARB_WFIFO_EN undefined: the write store is the single hold register; at most one write is outstanding.
- All other behaviour is identical in both builds.

## Test plan
- Write 0x5A to address 0, then vga_ce with x=0,y=0 or x=1,y=1 -> vga_color=0x5A two cycles after vga_ce.
- Write 0xC3 to address 321, then read at x=2,y=2 -> 0xC3; read at x=700,y=0 -> vga_color=0x00 and mem_we/mem_addr unchanged.
- Continuous vga_ce at 50% with visible coords plus a wr_valid burst of 8 writes -> every read captured correct data; all 8 writes land; the no-FIFO build shows wr_ready low for at least one cycle after each accept.
- Write to address 76800 -> wr_err=1 and stays set; RAM is never written.
- clr_req with clr_color=0x1F while a write is pending -> the pending write completes first; clr_busy stays high for at least 76800 cycles; every address then reads 0x1F.
- Assert reset_n mid-clear at counter ~1000 -> clr_busy=0, wr_ready=1 and vga_color=0 immediately; a new clr_req restarts the sweep from address 0.
